mem_stage_async: RTL and testbench

//  Next-generation MEM pipeline stage. It drives data memory through a split request/response

---
 rtl/mem_stage_async_pkg.sv | 41 ++++
 rtl/mem_stage_async_load_align.sv | 52 +++++
 rtl/mem_stage_async.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_async.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_async_pkg.sv
// Shared constants for the MEM stage: one-hot field indices, access size codes,
// handshake FSM states and the kseg0/kseg1 address translation constants.
package mem_stage_async_pkg;

  localparam int unsigned SEL_ALU  = 0;
  localparam int unsigned SEL_LOAD = 1;
  localparam int unsigned SEL_LWLR = 2;
  localparam int unsigned SEL_NNPC = 3;
  localparam int unsigned SEL_MF   = 4;

  localparam int unsigned LOAD_LB  = 0;
  localparam int unsigned LOAD_LBU = 1;
  localparam int unsigned LOAD_LH  = 2;
  localparam int unsigned LOAD_LHU = 3;
  localparam int unsigned LOAD_LW  = 4;
  localparam int unsigned LOAD_LWL = 5;
  localparam int unsigned LOAD_LWR = 6;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // VA[31:30]==2'b10 covers 0x8000_0000..0xBFFF_FFFF (kseg0/kseg1)
  localparam logic [1:0] KSEG01_TOP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  function automatic logic [1:0] size_from_strb(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_from_strb = SIZE_B;
      4'b0011, 4'b1100:                   size_from_strb = SIZE_H;
      default:                            size_from_strb = SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_async_load_align.sv
// Load data alignment: picks/extends the addressed byte or halfword and merges
// LWL/LWR partial words with the old rt value.
module mem_stage_async_load_align
  import mem_stage_async_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  vaddr_lo,
  input  logic [6:0]  load_type,
  input  logic [31:0] rt_old,
  output logic [31:0] wbdata,
  output logic [3:0]  reg_we
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (vaddr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = vaddr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wbdata = '0;
    reg_we = (|load_type) ? 4'b1111 : 4'b0000;
    if (load_type[LOAD_LB])       wbdata = {{24{byte_sel[7]}}, byte_sel};
    else if (load_type[LOAD_LBU]) wbdata = {24'd0, byte_sel};
    else if (load_type[LOAD_LH])  wbdata = {{16{half_sel[15]}}, half_sel};
    else if (load_type[LOAD_LHU]) wbdata = {16'd0, half_sel};
    else if (load_type[LOAD_LW])  wbdata = rdata;
    else if (load_type[LOAD_LWL]) begin
      case (vaddr_lo)
        2'd0:    wbdata = {rdata[7:0],  rt_old[23:0]};
        2'd1:    wbdata = {rdata[15:0], rt_old[15:0]};
        2'd2:    wbdata = {rdata[23:0], rt_old[7:0]};
        default: wbdata = rdata;
      endcase
    end else if (load_type[LOAD_LWR]) begin
      case (vaddr_lo)
        2'd0:    wbdata = rdata;
        2'd1:    wbdata = {rt_old[31:24], rdata[31:8]};
        2'd2:    wbdata = {rt_old[31:16], rdata[31:16]};
        default: wbdata = {rt_old[31:8],  rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_async.sv
// MEM pipeline stage driving data memory through a split req/addr_ok/data_ok
// handshake, with in-order discard of responses belonging to flushed requests.
module mem_stage_async
  import mem_stage_async_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DISCARD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exe_valid_in,
  output logic              mem_allowin_out,
  input  logic              wb_allowin_in,
  output logic              mem_valid_out,
  input  logic              flush_in,
  input  logic [4:0]        exe_sel_wbdata_in,
  input  logic [6:0]        exe_load_type_in,
  input  logic [3:0]        exe_mem_we_in,
  input  logic              exe_mem_re_in,
  input  logic [ADDR_W-1:0] exe_vaddr_in,
  input  logic [DATA_W-1:0] exe_wdata_in,
  input  logic [31:0]       exe_aluout_in,
  input  logic [31:0]       exe_nnpc_in,
  input  logic [31:0]       exe_pc_in,
  input  logic [31:0]       exe_rt_old_in,
  input  logic [4:0]        exe_regnum_in,
  input  logic [31:0]       mult_div_res_in,
  input  logic              mult_div_ok_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [31:0]       mem_wbdata_out,
  output logic [3:0]        mem_reg_we_out,
  output logic [31:0]       mem_pc_out,
  output logic [4:0]        mem_wnum_out,
  output logic              mem_busy_load_out
);

  localparam int unsigned DCW = $clog2(MAX_DISCARD + 1);
  localparam logic [ADDR_W-1:0] KSEG_MASK = {3'b000, {(ADDR_W-3){1'b1}}};

  logic              valid;
  mem_state_e        state;
  logic [DCW-1:0]    discard;
  logic [4:0]        sel;
  logic [6:0]        lt;
  logic [3:0]        we;
  logic              re;
  logic [ADDR_W-1:0] vaddr;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       aluout, nnpc, pc, rt_old;
  logic [4:0]        regnum;
  logic [DATA_W-1:0] hold;

  logic              is_mem, ready, resp_take, disc_inc, disc_dec;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       align_data;
  logic [3:0]        align_we, base_we;

  assign is_mem          = re | (|we);
  assign data_req        = valid && (state == ST_REQ) && (discard != DCW'(MAX_DISCARD));
  assign resp_take       = (state == ST_WAIT) && data_data_ok && (discard == '0);
  assign ready           = is_mem ? (state == ST_DONE) : (sel[SEL_MF] ? mult_div_ok_in : 1'b1);
  assign mem_valid_out   = valid && ready;
  assign mem_allowin_out = !valid || (mem_valid_out && wb_allowin_in);
  // A response arriving in the flush cycle is consumed here, so it is not counted as outstanding.
  assign disc_inc = flush_in && (((state == ST_WAIT) && !resp_take) ||
                                 ((state == ST_REQ) && data_req && data_addr_ok));
  assign disc_dec = data_data_ok && (discard != '0);

  assign paddr      = (vaddr[ADDR_W-1 -: 2] == KSEG01_TOP) ? (vaddr & KSEG_MASK) : vaddr;
  assign data_addr  = (lt[LOAD_LWL] | lt[LOAD_LWR]) ? {paddr[ADDR_W-1:2], 2'b00} : paddr;
  assign data_wr    = |we;
  assign data_wstrb = we;
  assign data_wdata = wdata;

  always_comb begin
    data_size = SIZE_B;
    if (re) begin
      if (lt[LOAD_LB] | lt[LOAD_LBU])      data_size = SIZE_B;
      else if (lt[LOAD_LH] | lt[LOAD_LHU]) data_size = SIZE_H;
      else                                 data_size = SIZE_W;
    end else if (|we) begin
      data_size = size_from_strb(we);
    end
  end

  mem_stage_async_load_align u_align (
    .rdata     (hold[31:0]),
    .vaddr_lo  (vaddr[1:0]),
    .load_type (lt),
    .rt_old    (rt_old),
    .wbdata    (align_data),
    .reg_we    (align_we)
  );

  always_comb begin
    mem_wbdata_out = ({32{sel[SEL_ALU]}}  & aluout) |
                     ({32{sel[SEL_LOAD] | sel[SEL_LWLR]}} & align_data) |
                     ({32{sel[SEL_NNPC]}} & nnpc) |
                     ({32{sel[SEL_MF]}}   & mult_div_res_in);
    if (sel[SEL_ALU] | sel[SEL_NNPC] | sel[SEL_MF]) base_we = 4'b1111;
    else if (sel[SEL_LOAD] | sel[SEL_LWLR])        base_we = align_we;
    else                                            base_we = 4'b0000;
    mem_reg_we_out = (mem_valid_out && (regnum != 5'd0)) ? base_we : 4'b0000;
  end

  assign mem_pc_out        = pc;
  assign mem_wnum_out      = regnum;
  assign mem_busy_load_out = valid && re && (state != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      state   <= ST_IDLE;
      discard <= '0;
      sel     <= '0;
      lt      <= '0;
      we      <= '0;
      re      <= 1'b0;
      vaddr   <= '0;
      wdata   <= '0;
      aluout  <= '0;
      nnpc    <= '0;
      pc      <= '0;
      rt_old  <= '0;
      regnum  <= '0;
      hold    <= '0;
    end else begin
      if (disc_inc && !disc_dec)      discard <= discard + DCW'(1);
      else if (!disc_inc && disc_dec) discard <= discard - DCW'(1);

      if (resp_take) hold <= data_rdata;

      if (flush_in) begin
        valid <= 1'b0;
        state <= ST_IDLE;
      end else if (mem_allowin_out) begin
        valid <= exe_valid_in;
        state <= ST_IDLE;
        if (exe_valid_in) begin
          sel    <= exe_sel_wbdata_in;
          lt     <= exe_load_type_in;
          we     <= exe_mem_we_in;
          re     <= exe_mem_re_in;
          vaddr  <= exe_vaddr_in;
          wdata  <= exe_wdata_in;
          aluout <= exe_aluout_in;
          nnpc   <= exe_nnpc_in;
          pc     <= exe_pc_in;
          rt_old <= exe_rt_old_in;
          regnum <= exe_regnum_in;
          if (exe_mem_re_in || (|exe_mem_we_in)) state <= ST_REQ;
        end
      end else begin
        case (state)
          ST_REQ:  if (data_req && data_addr_ok) state <= ST_WAIT;
          ST_WAIT: if (resp_take) state <= ST_DONE;
          default: state <= state;
        endcase
      end
    end
  end

  // Responses are in order: any data_ok must match a discarded or waiting request.
  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!rst_n)
    data_data_ok |-> ((discard != '0) || (state == ST_WAIT)));

endmodule

// File: tb/tb_mem_stage_async.sv
// Directed bench for mem_stage_async: table of load alignment vectors plus
// hand sequences for flush/discard, back-pressure, stores and async reset.
module tb_mem_stage_async;

  logic        clk, rst_n;
  logic        exe_valid_in, mem_allowin_out, wb_allowin_in, mem_valid_out, flush_in;
  logic [4:0]  exe_sel_wbdata_in;
  logic [6:0]  exe_load_type_in;
  logic [3:0]  exe_mem_we_in;
  logic        exe_mem_re_in;
  logic [31:0] exe_vaddr_in, exe_wdata_in, exe_aluout_in, exe_nnpc_in, exe_pc_in, exe_rt_old_in;
  logic [4:0]  exe_regnum_in;
  logic [31:0] mult_div_res_in;
  logic        mult_div_ok_in;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] mem_wbdata_out, mem_pc_out;
  logic [3:0]  mem_reg_we_out;
  logic [4:0]  mem_wnum_out;
  logic        mem_busy_load_out;

  mem_stage_async #(.ADDR_W(32), .DATA_W(32), .MAX_DISCARD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid_in(exe_valid_in), .mem_allowin_out(mem_allowin_out),
    .wb_allowin_in(wb_allowin_in), .mem_valid_out(mem_valid_out), .flush_in(flush_in),
    .exe_sel_wbdata_in(exe_sel_wbdata_in), .exe_load_type_in(exe_load_type_in),
    .exe_mem_we_in(exe_mem_we_in), .exe_mem_re_in(exe_mem_re_in),
    .exe_vaddr_in(exe_vaddr_in), .exe_wdata_in(exe_wdata_in),
    .exe_aluout_in(exe_aluout_in), .exe_nnpc_in(exe_nnpc_in), .exe_pc_in(exe_pc_in),
    .exe_rt_old_in(exe_rt_old_in), .exe_regnum_in(exe_regnum_in),
    .mult_div_res_in(mult_div_res_in), .mult_div_ok_in(mult_div_ok_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_wbdata_out(mem_wbdata_out), .mem_reg_we_out(mem_reg_we_out),
    .mem_pc_out(mem_pc_out), .mem_wnum_out(mem_wnum_out),
    .mem_busy_load_out(mem_busy_load_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LT_LB  = 7'b0000001, LT_LBU = 7'b0000010, LT_LH  = 7'b0000100,
                         LT_LHU = 7'b0001000, LT_LW  = 7'b0010000, LT_LWL = 7'b0100000,
                         LT_LWR = 7'b1000000;
  localparam logic [4:0] S_ALU = 5'b00001, S_LOAD = 5'b00010, S_LWLR = 5'b00100, S_MF = 5'b10000;

  typedef struct {
    logic [6:0]  lt;
    logic [31:0] va;
    logic [31:0] rd;
    logic [31:0] rt;
    logic [4:0]  rn;
    logic [31:0] exp_addr;
    logic [31:0] exp_wb;
    logic [3:0]  exp_we;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] sel, input logic [6:0] lt, input logic [3:0] we,
                       input logic re, input logic [31:0] va, input logic [31:0] wd,
                       input logic [31:0] rt, input logic [4:0] rn);
    chk("allowin_before_issue", mem_allowin_out, 1'b1);
    exe_valid_in = 1'b1;
    exe_sel_wbdata_in = sel; exe_load_type_in = lt; exe_mem_we_in = we; exe_mem_re_in = re;
    exe_vaddr_in = va; exe_wdata_in = wd; exe_rt_old_in = rt; exe_regnum_in = rn;
    @(negedge clk);
    exe_valid_in = 1'b0;
  endtask

  task automatic addr_hs();
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
  endtask

  task automatic resp(input logic [31:0] rd);
    data_data_ok = 1'b1;
    data_rdata = rd;
    @(negedge clk);
    data_data_ok = 1'b0;
    data_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_flush();
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{LT_LW,  32'h8000_0010, 32'h1234_5678, 32'h0,          5'd5, 32'h0000_0010, 32'h1234_5678, 4'hF};
    tbl[1] = '{LT_LB,  32'h0000_1003, 32'h80FF_FFFF, 32'h0,          5'd6, 32'h0000_1003, 32'hFFFF_FF80, 4'hF};
    tbl[2] = '{LT_LBU, 32'h0000_1003, 32'h80FF_FFFF, 32'h0,          5'd7, 32'h0000_1003, 32'h0000_0080, 4'hF};
    tbl[3] = '{LT_LH,  32'hA000_0102, 32'h80FF_FFFF, 32'h0,          5'd8, 32'h0000_0102, 32'hFFFF_80FF, 4'hF};
    tbl[4] = '{LT_LHU, 32'h0000_0200, 32'h1234_8765, 32'h0,          5'd9, 32'h0000_0200, 32'h0000_8765, 4'hF};
    tbl[5] = '{LT_LWL, 32'h0000_0041, 32'hAABB_CCDD, 32'h1122_3344, 5'd10, 32'h0000_0040, 32'hCCDD_3344, 4'hF};
    tbl[6] = '{LT_LWR, 32'h0000_0042, 32'hAABB_CCDD, 32'h1122_3344, 5'd11, 32'h0000_0040, 32'h1122_AABB, 4'hF};
    tbl[7] = '{LT_LW,  32'hC000_0000, 32'h5555_AAAA, 32'h0,          5'd0, 32'hC000_0000, 32'h5555_AAAA, 4'h0};
    tbl[8] = '{LT_LB,  32'hBFFF_FFFC, 32'h0000_007F, 32'h0,         5'd12, 32'h1FFF_FFFC, 32'h0000_007F, 4'hF};
    tbl[9] = '{LT_LBU, 32'h7FFF_FFFF, 32'hFE00_0000, 32'h0,         5'd13, 32'h7FFF_FFFF, 32'h0000_00FE, 4'hF};

    rst_n = 1'b0; exe_valid_in = 1'b0; wb_allowin_in = 1'b1; flush_in = 1'b0;
    exe_sel_wbdata_in = '0; exe_load_type_in = '0; exe_mem_we_in = '0; exe_mem_re_in = 1'b0;
    exe_vaddr_in = '0; exe_wdata_in = '0; exe_aluout_in = 32'hCAFE_0001; exe_nnpc_in = 32'h0000_1008;
    exe_pc_in = 32'hBFC0_0000; exe_rt_old_in = '0; exe_regnum_in = '0;
    mult_div_res_in = '0; mult_div_ok_in = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_valid", mem_valid_out, 1'b0);
    chk("rst_reg_we", mem_reg_we_out, 4'h0);
    chk("rst_wbdata", mem_wbdata_out, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_allowin", mem_allowin_out, 1'b1);

    // Load alignment table: addr_ok on first REQ cycle, data_ok two cycles later.
    for (int i = 0; i < NV; i++) begin
      issue(((tbl[i].lt & (LT_LWL | LT_LWR)) != 0) ? S_LWLR : S_LOAD, tbl[i].lt, 4'h0, 1'b1,
            tbl[i].va, 32'h0, tbl[i].rt, tbl[i].rn);
      chk($sformatf("v%0d_req", i), data_req, 1'b1);
      chk($sformatf("v%0d_addr", i), data_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_busy", i), mem_busy_load_out, 1'b1);
      addr_hs();
      @(negedge clk);
      resp(tbl[i].rd);
      chk($sformatf("v%0d_valid", i), mem_valid_out, 1'b1);
      chk($sformatf("v%0d_wbdata", i), mem_wbdata_out, tbl[i].exp_wb);
      chk($sformatf("v%0d_reg_we", i), mem_reg_we_out, tbl[i].exp_we);
      @(negedge clk);
    end

    // ALU op passes straight through with no memory request.
    issue(S_ALU, 7'h0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3);
    chk("alu_valid", mem_valid_out, 1'b1);
    chk("alu_wbdata", mem_wbdata_out, 32'hCAFE_0001);
    chk("alu_req", data_req, 1'b0);
    chk("alu_wnum", mem_wnum_out, 5'd3);
    @(negedge clk);

    // MF stalls until mult/div result is ready.
    issue(S_MF, 7'h0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd4);
    chk("mf_stall_valid", mem_valid_out, 1'b0);
    chk("mf_stall_allowin", mem_allowin_out, 1'b0);
    @(negedge clk);
    chk("mf_stall2_valid", mem_valid_out, 1'b0);
    mult_div_ok_in = 1'b1; mult_div_res_in = 32'h0BAD_CAFE;
    #1;
    chk("mf_valid", mem_valid_out, 1'b1);
    chk("mf_wbdata", mem_wbdata_out, 32'h0BAD_CAFE);
    @(negedge clk);
    mult_div_ok_in = 1'b0;

    // Halfword store: size/strobe/address, no register write.
    issue(5'b0, 7'h0, 4'b1100, 1'b0, 32'h8000_0102, 32'hBEEF_0000, 32'h0, 5'd0);
    chk("st_wr", data_wr, 1'b1);
    chk("st_strb", data_wstrb, 4'hC);
    chk("st_size", data_size, 2'd1);
    chk("st_addr", data_addr, 32'h0000_0102);
    chk("st_wdata", data_wdata, 32'hBEEF_0000);
    addr_hs();
    chk("st_wait_valid", mem_valid_out, 1'b0);
    resp(32'h0);
    chk("st_valid", mem_valid_out, 1'b1);
    chk("st_reg_we", mem_reg_we_out, 4'h0);
    @(negedge clk);

    // Flush in WAIT: the stale response is dropped, the next one delivered.
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0100, 32'h0, 32'h0, 5'd2);
    addr_hs();
    do_flush();
    chk("flw_valid", mem_valid_out, 1'b0);
    chk("flw_req", data_req, 1'b0);
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0104, 32'h0, 32'h0, 5'd2);
    chk("flw_new_req", data_req, 1'b1);
    chk("flw_new_addr", data_addr, 32'h0000_0104);
    addr_hs();
    resp(32'h1111_1111);
    chk("flw_drop_valid", mem_valid_out, 1'b0);
    resp(32'h2222_2222);
    chk("flw_deliver_valid", mem_valid_out, 1'b1);
    chk("flw_deliver_wbdata", mem_wbdata_out, 32'h2222_2222);
    @(negedge clk);

    // Flush in REQ without addr_ok: request withdrawn, nothing to discard.
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0108, 32'h0, 32'h0, 5'd2);
    do_flush();
    chk("flr_req", data_req, 1'b0);
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_010C, 32'h0, 32'h0, 5'd2);
    addr_hs();
    resp(32'h4444_4444);
    chk("flr_valid", mem_valid_out, 1'b1);
    chk("flr_wbdata", mem_wbdata_out, 32'h4444_4444);
    @(negedge clk);

    // Two flushed loads in flight: no new request until one response drains.
    for (int k = 0; k < 2; k++) begin
      issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0180, 32'h0, 32'h0, 5'd2);
      addr_hs();
      do_flush();
    end
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0200, 32'h0, 32'h0, 5'd2);
    chk("sat_req_blocked", data_req, 1'b0);
    @(negedge clk);
    chk("sat_req_blocked2", data_req, 1'b0);
    resp(32'h0DD0_0001);
    chk("sat_req_released", data_req, 1'b1);
    addr_hs();
    resp(32'h0DD0_0002);
    chk("sat_drop_valid", mem_valid_out, 1'b0);
    resp(32'h3333_3333);
    chk("sat_valid", mem_valid_out, 1'b1);
    chk("sat_wbdata", mem_wbdata_out, 32'h3333_3333);
    @(negedge clk);

    // WB back-pressure: result held, no new request, allowin low.
    wb_allowin_in = 1'b0;
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0300, 32'h0, 32'h0, 5'd2);
    addr_hs();
    resp(32'hA5A5_5A5A);
    for (int k = 0; k < 3; k++) begin
      data_rdata = 32'h1357_9BDF + k;
      chk("bp_valid", mem_valid_out, 1'b1);
      chk("bp_wbdata", mem_wbdata_out, 32'hA5A5_5A5A);
      chk("bp_allowin", mem_allowin_out, 1'b0);
      chk("bp_req", data_req, 1'b0);
      @(negedge clk);
    end
    wb_allowin_in = 1'b1;
    @(negedge clk);
    chk("bp_leave_valid", mem_valid_out, 1'b0);

    // Async reset mid-WAIT clears everything immediately.
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0400, 32'h0, 32'h0, 5'd2);
    addr_hs();
    chk("rw_busy", mem_busy_load_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", data_req, 1'b0);
    chk("rw_valid", mem_valid_out, 1'b0);
    chk("rw_reg_we", mem_reg_we_out, 4'h0);
    chk("rw_busy_cleared", mem_busy_load_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(S_LOAD, LT_LW, 4'h0, 1'b1, 32'h0000_0404, 32'h0, 32'h0, 5'd2);
    addr_hs();
    resp(32'h7777_0001);
    chk("rw_after_valid", mem_valid_out, 1'b1);
    chk("rw_after_wbdata", mem_wbdata_out, 32'h7777_0001);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
